// File: rtl/sos_multi_handler_pkg.sv
// Shared definitions for the elevator emergency handler: FSM encodings, source indices, defaults.
// Pure constants; no logic, no latency, no flow control.
package sos_multi_handler_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ALARM  = 2'b01;
  localparam logic [1:0] ST_HALTED = 2'b10;
  localparam logic [1:0] ST_CLEAR  = 2'b11;

  localparam int SRC_SOS_BTN  = 0;
  localparam int SRC_DOOR     = 1;
  localparam int SRC_OVERLOAD = 2;

  localparam int DEF_DEBOUNCE   = 4;
  localparam int DEF_CLEAR_HOLD = 8;
  localparam int DEF_BEEP_HALF  = 16;

endpackage

// File: rtl/sos_multi_handler_debouncer.sv
// One alarm bit: 2-flop synchroniser, debounce counter, single-cycle qualify pulse.
// Qualifies on the DEBOUNCE-th enabled synced-high cycle; no backpressure (level input).
module sos_debouncer #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  input  logic en_i,
  output logic active_o,
  output logic qual_o
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);
  localparam logic [CW-1:0] QUAL_AT = CW'(DEBOUNCE - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign active_o = sync2_q & en_i;
  assign qual_o   = active_o && (cnt_q == QUAL_AT);

  // Saturating at DEBOUNCE keeps a long high level to exactly one event.
  always_comb begin
    cnt_d = '0;
    if (active_o) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/sos_multi_handler.sv
// Emergency handler: debounced alarm sources latch pending bits and drive sos_mode/stop until key clear.
// Event visible DEBOUNCE+2 edges after input high; all outputs registered; no backpressure.
module sos_multi_handler
  import sos_multi_handler_pkg::*;
#(
  parameter int N_SRC      = 3,
  parameter int DEBOUNCE   = DEF_DEBOUNCE,
  parameter int CLEAR_HOLD = DEF_CLEAR_HOLD,
  parameter int BEEP_HALF  = DEF_BEEP_HALF,
  localparam int FCW = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] sos_req,
  input  logic [N_SRC-1:0] src_mask,
  input  logic             reset_key,
  input  logic             cabin_stopped,
  output logic             sos_mode,
  output logic             stop_request,
  output logic             alarm_beep,
  output logic [FCW-1:0]   first_cause,
  output logic [N_SRC-1:0] pending,
  output logic [1:0]       state_o
);

  localparam int HW = $clog2(CLEAR_HOLD + 1);
  localparam int BW = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
  localparam logic [HW-1:0] HOLD_MAX  = HW'(CLEAR_HOLD);
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_HALF - 1);

  logic [N_SRC-1:0] qual;
  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] cand;
  logic             key_sync1_q;
  logic             key_sync2_q;
  logic [1:0]       state_q,   state_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [FCW-1:0]   cause_q,   cause_d;
  logic [HW-1:0]    hold_q,    hold_d;
  logic             beep_q,    beep_d;
  logic [BW-1:0]    bcnt_q,    bcnt_d;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    sos_debouncer #(
      .DEBOUNCE(DEBOUNCE)
    ) u_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_i   (sos_req[g]),
      .en_i    (src_mask[g]),
      .active_o(active[g]),
      .qual_o  (qual[g])
    );
  end

  // A bit kept across the CLEAR->IDLE edge re-opens the alarm from pending alone.
  assign cand = pending_q | qual;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | qual;
    cause_d   = cause_q;
    hold_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (|cand) begin
          state_d = ST_ALARM;
          for (int i = N_SRC - 1; i >= 0; i--) begin
            if (cand[i]) cause_d = FCW'(i);
          end
        end
      end
      ST_ALARM: begin
        if (cabin_stopped) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (key_sync2_q && !(|active) && !(|qual)) hold_d = hold_q + 1'b1;
        if (hold_d == HOLD_MAX) begin
          state_d = ST_CLEAR;
          hold_d  = '0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        pending_d = qual;
        cause_d   = '0;
      end
    endcase
  end

  always_comb begin
    beep_d = beep_q;
    bcnt_d = bcnt_q;
    if (state_d == ST_IDLE) begin
      beep_d = 1'b0;
      bcnt_d = '0;
    end else if (state_q == ST_IDLE) begin
      beep_d = 1'b1;
      bcnt_d = '0;
    end else if (bcnt_q == BEEP_LAST) begin
      beep_d = ~beep_q;
      bcnt_d = '0;
    end else begin
      bcnt_d = bcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_sync1_q <= 1'b0;
      key_sync2_q <= 1'b0;
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      cause_q     <= '0;
      hold_q      <= '0;
      beep_q      <= 1'b0;
      bcnt_q      <= '0;
    end else begin
      key_sync1_q <= reset_key;
      key_sync2_q <= key_sync1_q;
      state_q     <= state_d;
      pending_q   <= pending_d;
      cause_q     <= cause_d;
      hold_q      <= hold_d;
      beep_q      <= beep_d;
      bcnt_q      <= bcnt_d;
    end
  end

  assign sos_mode     = (state_q != ST_IDLE);
  assign stop_request = (state_q == ST_ALARM) || (state_q == ST_HALTED);
  assign alarm_beep   = beep_q;
  assign first_cause  = cause_q;
  assign pending      = pending_q;
  assign state_o      = state_q;

endmodule
